// File: rtl/sram_like_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_pkg
// Brief    : Shared ids, bus widths and grant helper for the sram-like arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_like_arbiter_pkg;

  localparam logic SRAM_ID_INST    = 1'b0;
  localparam logic SRAM_ID_DATA    = 1'b1;
  // size + wstrb + addr + wdata; wr travels separately
  localparam int   SRAM_REQ_BUS_WD = 70;

  typedef enum logic {
    ID_INST = SRAM_ID_INST,
    ID_DATA = SRAM_ID_DATA
  } sram_id_e;

  function automatic sram_id_e pick_winner(input logic     inst_req,
                                           input logic     data_req,
                                           input sram_id_e tie_id);
    sram_id_e win;
    if (inst_req && data_req) win = tie_id;
    else if (data_req)        win = ID_DATA;
    else if (inst_req)        win = ID_INST;
    else                      win = tie_id;
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter_if
// Brief    : One sram-like port; master drives the request, slave answers.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_arbiter_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_id_fifo
// Brief    : 1-bit wide id FIFO recording which master owns each outstanding
//            transaction, oldest at the head.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  wire logic clk,
  input  wire logic resetn,
  input  wire logic push,
  input  wire logic push_id,
  input  wire logic pop,
  output logic      full,
  output logic      empty,
  output logic      head
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] slots_q,  slots_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = slots_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      slots_d[wr_ptr_q] = push_id;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slots_q  <= slots_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Brief    : Shares one sram-like memory port between the inst and data
//            masters; routes in-order responses back to their issuers.
//            Define SRAM_ARB_RR_EN for round-robin ties (default: fixed).
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIO       = 1
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  sram_like_arbiter_if.slave  inst_sram,
  sram_like_arbiter_if.slave  data_sram,
  sram_like_arbiter_if.master mem
);

  localparam sram_id_e PRIO_ID = (DATA_PRIO != 0) ? ID_DATA : ID_INST;

  logic                       lock_q,    lock_d;
  sram_id_e                   lock_id_q, lock_id_d;
  sram_id_e                   tie_id;
  sram_id_e                   winner;
  sram_id_e                   head_id;
  logic                       winner_req;
  logic                       winner_wr;
  logic                       issue;
  logic                       accept;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_head;
  logic                       resp_valid;
  logic                       inst_data_ok;
  logic                       data_data_ok;
  logic [SRAM_REQ_BUS_WD-1:0] inst_bus;
  logic [SRAM_REQ_BUS_WD-1:0] data_bus;
  logic [SRAM_REQ_BUS_WD-1:0] win_bus;

`ifdef SRAM_ARB_RR_EN
  sram_id_e rr_q, rr_d;

  // rr_q names the port that wins the next tie; the port just accepted yields.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (winner == ID_DATA) ? ID_INST : ID_DATA;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q <= PRIO_ID;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign tie_id = rr_q;
`else
  assign tie_id = PRIO_ID;
`endif

  always_comb begin
    winner     = lock_q ? lock_id_q : pick_winner(inst_sram.req, data_sram.req, tie_id);
    winner_req = (winner == ID_DATA) ? data_sram.req : inst_sram.req;
    winner_wr  = (winner == ID_DATA) ? data_sram.wr  : inst_sram.wr;
  end

  // Full comes from the registered count, so a same-cycle response never
  // reopens issue and there is no data_ok -> req path.
  assign issue  = winner_req & ~fifo_full;
  assign accept = issue & mem.addr_ok;

  assign inst_bus = {inst_sram.size, inst_sram.wstrb, inst_sram.addr, inst_sram.wdata};
  assign data_bus = {data_sram.size, data_sram.wstrb, data_sram.addr, data_sram.wdata};
  assign win_bus  = (winner == ID_DATA) ? data_bus : inst_bus;

  assign mem.req = issue;
  assign mem.wr  = issue & winner_wr;
  assign {mem.size, mem.wstrb, mem.addr, mem.wdata} = issue ? win_bus : '0;

  assign inst_sram.addr_ok = accept & (winner == ID_INST);
  assign data_sram.addr_ok = accept & (winner == ID_DATA);

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (issue && !mem.addr_ok) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end else if (accept) begin
      lock_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= PRIO_ID;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  sram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (winner),
    .pop     (resp_valid),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // A response with nothing outstanding is dropped silently.
  assign resp_valid   = mem.data_ok & ~fifo_empty;
  assign head_id      = sram_id_e'(fifo_head);
  assign inst_data_ok = resp_valid & (head_id == ID_INST);
  assign data_data_ok = resp_valid & (head_id == ID_DATA);

  assign inst_sram.data_ok = inst_data_ok;
  assign data_sram.data_ok = data_data_ok;
  assign inst_sram.rdata   = inst_data_ok ? mem.rdata : '0;
  assign data_sram.rdata   = data_data_ok ? mem.rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Brief    : Self-checking bench for sram_like_arbiter: directed scenarios plus
//            random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_like_arbiter;

  localparam int MAXO  = 2;
  localparam int DPRIO = 1;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if mem_if ();

  sram_like_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .DATA_PRIO       (DPRIO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if)
  );

  task automatic idle_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0; inst_if.wstrb = 4'h0;
    inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0; data_if.wstrb = 4'h0;
    data_if.addr = 32'h0; data_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = 32'h12345678;
    @(posedge clk);
    #2;
    total++;
    if ({mem_if.req, mem_if.wr, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok} !== 6'b0) begin
      bad++;
      $display("FAIL reset_handshakes: got %b want 000000",
               {mem_if.req, mem_if.wr, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok});
    end
    total++;
    if ({inst_if.rdata, data_if.rdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0 0", inst_if.rdata, data_if.rdata);
    end
    total++;
    if (mem_if.addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem_addr: got %h want 0", mem_if.addr);
    end
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_inst_only();
    do_reset();
    inst_if.req = 1'b1; inst_if.size = 2'd2; inst_if.addr = 32'h1c000000;
    mem_if.addr_ok = 1'b1;
    settle();
    total++;
    if ({mem_if.req, inst_if.addr_ok, data_if.addr_ok} !== 3'b110) begin
      bad++;
      $display("FAIL inst_only_accept: got req/iaok/daok=%b want 110", {mem_if.req, inst_if.addr_ok, data_if.addr_ok});
    end
    total++;
    if (mem_if.addr !== 32'h1c000000) begin
      bad++;
      $display("FAIL inst_only_addr: got %h want 1c000000", mem_if.addr);
    end
    tick();
    inst_if.req = 1'b0; inst_if.addr = 32'h0; mem_if.addr_ok = 1'b0;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok, mem_if.req} !== 3'b000) begin
      bad++;
      $display("FAIL inst_only_gap: got %b want 000", {inst_if.data_ok, data_if.data_ok, mem_if.req});
    end
    tick();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEADBEEF;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin
      bad++;
      $display("FAIL inst_only_data_ok: got i/d=%b want 10", {inst_if.data_ok, data_if.data_ok});
    end
    total++;
    if (inst_if.rdata !== 32'hDEADBEEF || data_if.rdata !== 32'h0) begin
      bad++;
      $display("FAIL inst_only_rdata: got %h/%h want deadbeef/0", inst_if.rdata, data_if.rdata);
    end
    tick();
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_priority();
    logic first_data;
    first_data = (DPRIO != 0);
    do_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00001000;
    data_if.req = 1'b1; data_if.addr = 32'h00002000; data_if.wr = 1'b1;
    data_if.wstrb = 4'hF; data_if.wdata = 32'hA5A5A5A5;
    mem_if.addr_ok = 1'b1;
    settle();
    total++;
    if ({data_if.addr_ok, inst_if.addr_ok} !== (first_data ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL prio_first_grant: got d/i=%b want data_first=%0b", {data_if.addr_ok, inst_if.addr_ok}, first_data);
    end
    total++;
    if ({mem_if.addr, mem_if.wr, mem_if.wdata} !== {32'h00002000, 1'b1, 32'hA5A5A5A5}) begin
      bad++;
      $display("FAIL prio_first_fields: got addr=%h wr=%b wdata=%h want 2000/1/a5a5a5a5",
               mem_if.addr, mem_if.wr, mem_if.wdata);
    end
    tick();
    data_if.req = 1'b0; data_if.wr = 1'b0;
    settle();
    total++;
    if ({inst_if.addr_ok, mem_if.addr} !== {1'b1, 32'h00001000}) begin
      bad++;
      $display("FAIL prio_second_grant: got iaok=%b addr=%h want 1/1000", inst_if.addr_ok, mem_if.addr);
    end
    tick();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11111111;
    settle();
    total++;
    if ({data_if.data_ok, inst_if.data_ok, data_if.rdata} !== {2'b10, 32'h11111111}) begin
      bad++;
      $display("FAIL prio_resp1: got d/i=%b rdata=%h want 10/11111111", {data_if.data_ok, inst_if.data_ok}, data_if.rdata);
    end
    tick();
    mem_if.rdata = 32'h22222222;
    settle();
    total++;
    if ({data_if.data_ok, inst_if.data_ok, inst_if.rdata} !== {2'b01, 32'h22222222}) begin
      bad++;
      $display("FAIL prio_resp2: got d/i=%b rdata=%h want 01/22222222", {data_if.data_ok, inst_if.data_ok}, inst_if.rdata);
    end
    tick();
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          order[$];
    int          tie;
    int          win;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] exp_rd;
    do_reset();
    tie = DPRIO;
    ia  = 32'h1c000100;
    da  = 32'h2c000200;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        inst_if.req = 1'b1; inst_if.addr = ia;
        data_if.req = 1'b1; data_if.addr = da;
        mem_if.addr_ok = 1'b1;
      end else begin
        inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      end
      exp_rd         = 32'hC0DE0000 + 32'(k);
      mem_if.data_ok = (k >= 1);
      mem_if.rdata   = exp_rd;
      win            = tie;
      settle();
      if (k < 4) begin
        total++;
        if ({data_if.addr_ok, inst_if.addr_ok} !== (win == 1 ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL b2b_grant[%0d]: got d/i=%b want winner=%0d", k, {data_if.addr_ok, inst_if.addr_ok}, win);
        end
        total++;
        if (mem_if.addr !== (win == 1 ? da : ia)) begin
          bad++;
          $display("FAIL b2b_addr[%0d]: got %h want %h", k, mem_if.addr, (win == 1 ? da : ia));
        end
        order.push_back(win);
      end
      if (k >= 1) begin
        total++;
        if ({data_if.data_ok, inst_if.data_ok} !== (order[k-1] == 1 ? 2'b10 : 2'b01)
            || (order[k-1] == 1 ? data_if.rdata : inst_if.rdata) !== exp_rd) begin
          bad++;
          $display("FAIL b2b_resp[%0d]: got d/i=%b rdata i=%h d=%h want owner=%0d rdata=%h",
                   k, {data_if.data_ok, inst_if.data_ok}, inst_if.rdata, data_if.rdata, order[k-1], exp_rd);
        end
      end
`ifdef SRAM_ARB_RR_EN
      if (k < 4) tie = 1 - win;
`endif
      if (k < 4) begin
        if (win == 1) da = da + 32'h4;
        else          ia = ia + 32'h4;
      end
      tick();
    end
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000010;
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) begin
        data_if.req = 1'b1; data_if.addr = 32'h2c000020;
      end
      mem_if.addr_ok = (k == 3);
      settle();
      total++;
      if ({mem_if.req, mem_if.addr, inst_if.addr_ok, data_if.addr_ok} !== {1'b1, 32'h1c000010, (k == 3), 1'b0}) begin
        bad++;
        $display("FAIL lock_hold[%0d]: got req=%b addr=%h i/d aok=%b%b want 1/1c000010/%0b0",
                 k, mem_if.req, mem_if.addr, inst_if.addr_ok, data_if.addr_ok, (k == 3));
      end
      tick();
    end
    inst_if.req = 1'b0;
    settle();
    total++;
    if ({mem_if.addr, data_if.addr_ok, inst_if.addr_ok} !== {32'h2c000020, 2'b10}) begin
      bad++;
      $display("FAIL lock_release: got addr=%h d/i aok=%b%b want 2c000020/10",
               mem_if.addr, data_if.addr_ok, inst_if.addr_ok);
    end
    tick();
    data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    mem_if.addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      inst_if.req = 1'b1; inst_if.addr = 32'h10 + 32'(4 * k);
      settle();
      total++;
      if (inst_if.addr_ok !== 1'b1) begin
        bad++;
        $display("FAIL full_fill[%0d]: got iaok=%b want 1", k, inst_if.addr_ok);
      end
      tick();
    end
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h20;
    settle();
    total++;
    if ({mem_if.req, data_if.addr_ok} !== 2'b00) begin
      bad++;
      $display("FAIL full_block: got req/daok=%b want 00", {mem_if.req, data_if.addr_ok});
    end
    tick();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h33;
    settle();
    total++;
    if ({mem_if.req, data_if.addr_ok, inst_if.data_ok} !== 3'b001) begin
      bad++;
      $display("FAIL full_pop_cycle: got req/daok/idok=%b want 001", {mem_if.req, data_if.addr_ok, inst_if.data_ok});
    end
    tick();
    mem_if.data_ok = 1'b0;
    settle();
    total++;
    if ({mem_if.req, data_if.addr_ok, mem_if.addr} !== {2'b11, 32'h20}) begin
      bad++;
      $display("FAIL full_resume: got req/daok=%b%b addr=%h want 11/20", mem_if.req, data_if.addr_ok, mem_if.addr);
    end
    tick();
    data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h44;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'h44}) begin
      bad++;
      $display("FAIL full_drain1: got i/d=%b rdata=%h want 10/44", {inst_if.data_ok, data_if.data_ok}, inst_if.rdata);
    end
    tick();
    mem_if.rdata = 32'h55;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok, data_if.rdata} !== {2'b01, 32'h55}) begin
      bad++;
      $display("FAIL full_drain2: got i/d=%b rdata=%h want 01/55", {inst_if.data_ok, data_if.data_ok}, data_if.rdata);
    end
    tick();
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000100; mem_if.addr_ok = 1'b1;
    tick();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    tick();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h00000BAD;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL arst_drop: got i/d data_ok=%b want 00", {inst_if.data_ok, data_if.data_ok});
    end
    tick();
    mem_if.data_ok = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000200; mem_if.addr_ok = 1'b1;
    settle();
    total++;
    if ({inst_if.addr_ok, mem_if.addr} !== {1'b1, 32'h1c000200}) begin
      bad++;
      $display("FAIL arst_next_req: got iaok=%b addr=%h want 1/1c000200", inst_if.addr_ok, mem_if.addr);
    end
    tick();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000600D;
    settle();
    total++;
    if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'h0000600D}) begin
      bad++;
      $display("FAIL arst_next_resp: got i/d=%b rdata=%h want 10/600d", {inst_if.data_ok, data_if.data_ok}, inst_if.rdata);
    end
    tick();
    mem_if.data_ok = 1'b0;
  endtask

  // Reference: outstanding owners in a queue, the offered-but-unaccepted owner
  // held until accepted, ties resolved by priority or by "last accepted yields".
  task automatic test_random();
    int          owners[$];
    int          held;
    int          tie;
    int          cand;
    int          resp;
    logic        ipend, dpend, aok, dok, full, exp_req, acc;
    logic [70:0] ibus, dbus, exp_bus;
    logic [31:0] rd;
    do_reset();
    held  = -1;
    tie   = DPRIO;
    ipend = 1'b0;
    dpend = 1'b0;
    ibus  = '0;
    dbus  = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1'b1;
        ibus  = {$urandom, $urandom, 7'($urandom)};
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1;
        dbus  = {$urandom, $urandom, 7'($urandom)};
      end
      inst_if.req = ipend;
      data_if.req = dpend;
      {inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.addr, inst_if.wdata} = ibus;
      {data_if.wr, data_if.size, data_if.wstrb, data_if.addr, data_if.wdata} = dbus;
      aok = 1'($urandom_range(0, 1));
      if (owners.size() > 0) dok = ($urandom_range(0, 2) != 0);
      else                   dok = ($urandom_range(0, 5) == 0);
      rd             = $urandom;
      mem_if.addr_ok = aok;
      mem_if.data_ok = dok;
      mem_if.rdata   = rd;

      full = (owners.size() >= MAXO);
      if (held >= 0)           cand = held;
      else if (ipend && dpend) cand = tie;
      else if (dpend)          cand = 1;
      else if (ipend)          cand = 0;
      else                     cand = -1;
      exp_req = (cand >= 0) && !full;
      acc     = exp_req && aok;
      exp_bus = (cand == 1) ? dbus : ibus;
      resp    = (dok && owners.size() > 0) ? owners[0] : -1;

      settle();
      total++;
      if (mem_if.req !== exp_req) begin
        bad++;
        $display("FAIL rnd_mem_req[%0d]: got %b want %b", c, mem_if.req, exp_req);
      end
      if (exp_req) begin
        total++;
        if ({mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata} !== exp_bus) begin
          bad++;
          $display("FAIL rnd_mem_fields[%0d]: got %h want %h", c,
                   {mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata}, exp_bus);
        end
      end
      total++;
      if ({inst_if.addr_ok, data_if.addr_ok} !== {acc && cand == 0, acc && cand == 1}) begin
        bad++;
        $display("FAIL rnd_addr_ok[%0d]: got i/d=%b%b want %b%b", c, inst_if.addr_ok, data_if.addr_ok,
                 acc && cand == 0, acc && cand == 1);
      end
      total++;
      if ({inst_if.data_ok, data_if.data_ok} !== {resp == 0, resp == 1}
          || inst_if.rdata !== (resp == 0 ? rd : 32'h0)
          || data_if.rdata !== (resp == 1 ? rd : 32'h0)) begin
        bad++;
        $display("FAIL rnd_resp[%0d]: got i/d=%b%b rdata %h/%h want owner=%0d rdata=%h", c,
                 inst_if.data_ok, data_if.data_ok, inst_if.rdata, data_if.rdata, resp, rd);
      end

      if (resp >= 0) void'(owners.pop_front());
      if (acc) owners.push_back(cand);
      if (exp_req && !aok) held = cand;
      else if (acc)        held = -1;
`ifdef SRAM_ARB_RR_EN
      if (acc) tie = 1 - cand;
`endif
      if (acc && cand == 0) ipend = 1'b0;
      if (acc && cand == 1) dpend = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_inst_only();
    test_priority();
    test_back_to_back();
    test_lock();
    test_full();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
